// File: rtl/unpacker_pkt_arb.sv
// Packet-granular round-robin arbiter feeding the unpacker input port.
// Optional stall timeout is enabled with `define UNPACKER_ARB_TIMEOUT_EN.
module unpacker_pkt_arb #(
   parameter int NUM_REQ     = 4,
   parameter int IN_IFC_SZ_B = 160,
   parameter int VBC_W       = 8
`ifdef UNPACKER_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQ-1:0]                 req_val,
   input  logic [NUM_REQ-1:0]                 req_sop,
   input  logic [NUM_REQ-1:0]                 req_eop,
   input  logic [NUM_REQ*VBC_W-1:0]           req_vbc,
   input  logic [NUM_REQ*IN_IFC_SZ_B*8-1:0]   req_data,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               out_val,
   output logic                               out_sop,
   output logic                               out_eop,
   output logic [VBC_W-1:0]                   out_vbc,
   output logic [IN_IFC_SZ_B*8-1:0]           out_data,
   input  logic                               out_ready,
   output logic [$clog2(NUM_REQ)-1:0]         gnt_id,
   output logic                               busy,
   output logic                               err,
   output logic [1:0]                         err_code
);

   localparam int GID_W  = $clog2(NUM_REQ);
   localparam int DATA_W = IN_IFC_SZ_B * 8;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

   state_t             state_r;
   logic [GID_W-1:0]   rr_ptr_r;
   logic [GID_W-1:0]   gnt_id_r;
   logic [15:0]        word_cnt_r;
   logic               err_r;
   logic [1:0]         err_code_r;

   logic [VBC_W-1:0]   vbc_a_s  [NUM_REQ];
   logic [DATA_W-1:0]  data_a_s [NUM_REQ];
   logic               found_s;
   logic [GID_W-1:0]   win_s;
   logic [GID_W-1:0]   idx_s;
   logic [GID_W-1:0]   rr_next_s;
   logic               xfer_s;
   logic               vbc_bad_s;
   logic [31:0]        vbc_ext_s;
   logic               err_det_s;
   logic [1:0]         err_code_s;
   logic               timeout_s;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign vbc_a_s[i]  = req_vbc[i*VBC_W +: VBC_W];
      assign data_a_s[i] = req_data[i*DATA_W +: DATA_W];
   end

   assign gnt_id    = gnt_id_r;
   assign busy      = (state_r == ST_LOCK);
   assign err       = err_r;
   assign err_code  = err_code_r;
   assign xfer_s    = (state_r == ST_LOCK) && out_val && out_ready;
   assign rr_next_s = (gnt_id_r == GID_W'(NUM_REQ - 1)) ? {GID_W{1'b0}} : gnt_id_r + GID_W'(1);
   assign vbc_ext_s = 32'(out_vbc);
   assign vbc_bad_s = (out_vbc == {VBC_W{1'b0}}) || (vbc_ext_s > 32'(IN_IFC_SZ_B));

   // Output mux: only the locked requester is visible downstream
   always_comb begin
      req_ready = {NUM_REQ{1'b0}};
      if (state_r == ST_LOCK) begin
         out_val             = req_val[gnt_id_r];
         out_sop             = req_sop[gnt_id_r];
         out_eop             = req_eop[gnt_id_r];
         out_vbc             = vbc_a_s[gnt_id_r];
         out_data            = data_a_s[gnt_id_r];
         req_ready[gnt_id_r] = out_ready;
      end else begin
         out_val  = 1'b0;
         out_sop  = 1'b0;
         out_eop  = 1'b0;
         out_vbc  = {VBC_W{1'b0}};
         out_data = {DATA_W{1'b0}};
      end
   end

   // Round-robin search for a packet start, beginning at rr_ptr
   always_comb begin
      found_s = 1'b0;
      win_s   = {GID_W{1'b0}};
      idx_s   = {GID_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = GID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
         if (!found_s && req_val[idx_s] && req_sop[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

`ifdef UNPACKER_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
   logic [STALL_W-1:0] stall_cnt_r;

   assign timeout_s = (state_r == ST_LOCK) && !xfer_s &&
                      (stall_cnt_r == STALL_W'(TIMEOUT_CYC - 1));

   // Stall counter: held at zero outside LOCK so entry to LOCK starts clean
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= {STALL_W{1'b0}};
      end else if (state_r != ST_LOCK || xfer_s || timeout_s) begin
         stall_cnt_r <= {STALL_W{1'b0}};
      end else begin
         stall_cnt_r <= stall_cnt_r + STALL_W'(1);
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Error classification; the lowest code takes priority
   always_comb begin
      err_det_s  = 1'b0;
      err_code_s = 2'd0;
      if (xfer_s && out_sop && (word_cnt_r != 16'd0)) begin
         err_det_s  = 1'b1;
         err_code_s = 2'd0;
      end else if (xfer_s && !out_sop && (word_cnt_r == 16'd0)) begin
         err_det_s  = 1'b1;
         err_code_s = 2'd1;
      end else if (xfer_s && vbc_bad_s) begin
         err_det_s  = 1'b1;
         err_code_s = 2'd2;
      end else if (timeout_s) begin
         err_det_s  = 1'b1;
         err_code_s = 2'd3;
      end else begin
         err_det_s  = 1'b0;
         err_code_s = 2'd0;
      end
   end

   // Arbitration FSM, grant lock and registered error pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= {GID_W{1'b0}};
         gnt_id_r   <= {GID_W{1'b0}};
         word_cnt_r <= 16'd0;
         err_r      <= 1'b0;
         err_code_r <= 2'd0;
      end else begin
         err_r <= err_det_s;
         if (err_det_s) begin
            err_code_r <= err_code_s;
         end else begin
            err_code_r <= err_code_r;
         end
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  gnt_id_r <= win_s;
                  state_r  <= ST_LOCK;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_LOCK: begin
               if (xfer_s && out_eop) begin
                  rr_ptr_r   <= rr_next_s;
                  word_cnt_r <= 16'd0;
                  state_r    <= ST_IDLE;
               end else if (xfer_s) begin
                  word_cnt_r <= word_cnt_r + 16'd1;
               end else if (timeout_s) begin
                  // Abandon the stalled packet without generating an eop
                  rr_ptr_r   <= rr_next_s;
                  word_cnt_r <= 16'd0;
                  state_r    <= ST_IDLE;
               end else begin
                  state_r    <= ST_LOCK;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unpacker_pkt_arb.sv
// Directed self-checking bench for unpacker_pkt_arb (NUM_REQ=4, 160B bus).
module tb_unpacker_pkt_arb;

   localparam int NR = 4;
   localparam int IB = 160;
   localparam int VW = 8;
   localparam int DW = IB * 8;

   logic              clk;
   logic              reset;
   logic [NR-1:0]     req_val, req_sop, req_eop, req_ready;
   logic [NR*VW-1:0]  req_vbc;
   logic [NR*DW-1:0]  req_data;
   logic              out_val, out_sop, out_eop, out_ready;
   logic [VW-1:0]     out_vbc;
   logic [DW-1:0]     out_data;
   logic [1:0]        gnt_id;
   logic              busy, err;
   logic [1:0]        err_code;
   logic [DW-1:0]     exp_d;
   int                n_pass;
   int                n_total;

   unpacker_pkt_arb #(.NUM_REQ(NR), .IN_IFC_SZ_B(IB), .VBC_W(VW)) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_sop(req_sop), .req_eop(req_eop),
      .req_vbc(req_vbc), .req_data(req_data), .req_ready(req_ready),
      .out_val(out_val), .out_sop(out_sop), .out_eop(out_eop),
      .out_vbc(out_vbc), .out_data(out_data), .out_ready(out_ready),
      .gnt_id(gnt_id), .busy(busy), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic s, input logic e,
                          input logic [VW-1:0] vbc, input logic [7:0] tag);
      req_val[i]            = v;
      req_sop[i]            = s;
      req_eop[i]            = e;
      req_vbc[i*VW +: VW]   = vbc;
      req_data[i*DW +: DW]  = {IB{tag}};
   endtask

   task automatic test_reset();
      set_req(0, 1'b1, 1'b1, 1'b1, 8'd64, 8'hEE);
      out_ready = 1'b1;
      #3;
      n_total++; if (out_val !== 1'b0) $display("FAIL rst_out_val: got %0b want 0", out_val); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready: got %b want 0000", req_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
      n_total++; if (gnt_id !== 2'd0) $display("FAIL rst_gnt_id: got %0d want 0", gnt_id); else n_pass++;
      n_total++; if ({err, err_code} !== 3'b000) $display("FAIL rst_err: got %b want 000", {err, err_code}); else n_pass++;
      step();
      step();
      reset = 1'b0;
      set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %0b want 0", busy); else n_pass++;
   endtask

   task automatic test_single();
      step();
      set_req(0, 1'b1, 1'b1, 1'b1, 8'd64, 8'hA0);
      @(negedge clk);
      n_total++; if (out_val !== 1'b0) $display("FAIL single_idle_val: got %0b want 0", out_val); else n_pass++;
      step();
      @(negedge clk);
      exp_d = {IB{8'hA0}};
      n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", busy); else n_pass++;
      n_total++; if (out_val !== 1'b1) $display("FAIL single_val: got %0b want 1", out_val); else n_pass++;
      n_total++; if ({out_sop, out_eop} !== 2'b11) $display("FAIL single_sop_eop: got %b want 11", {out_sop, out_eop}); else n_pass++;
      n_total++; if (out_vbc !== 8'd64) $display("FAIL single_vbc: got %0d want 64", out_vbc); else n_pass++;
      n_total++; if (out_data !== exp_d) $display("FAIL single_data: got %0h want %0h", out_data[15:0], exp_d[15:0]); else n_pass++;
      n_total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
      step();
      set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      n_total++; if ({busy, out_val, req_ready} !== 6'b0) $display("FAIL single_done: got %b want 000000", {busy, out_val, req_ready}); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL single_err: got %0b want 0", err); else n_pass++;
      // rr_ptr is now 1, so requester 1 beats requester 0
      step();
      set_req(0, 1'b1, 1'b1, 1'b1, 8'd8, 8'h01);
      set_req(1, 1'b1, 1'b1, 1'b1, 8'd8, 8'h02);
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd1) $display("FAIL single_rrptr_gnt: got %0d want 1", gnt_id); else n_pass++;
      n_total++; if (req_ready !== 4'b0010) $display("FAIL single_rrptr_ready: got %b want 0010", req_ready); else n_pass++;
      step();
      set_req(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL single_gap: got %0b want 0", busy); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd0) $display("FAIL single_wrap_gnt: got %0d want 0", gnt_id); else n_pass++;
      step();
      set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
   endtask

   task automatic test_mid_reset();
      step();
      set_req(2, 1'b1, 1'b1, 1'b0, 8'd160, 8'h30);
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd2) $display("FAIL mrst_gnt: got %0d want 2", gnt_id); else n_pass++;
      step();
      set_req(2, 1'b1, 1'b0, 1'b1, 8'd1, 8'h31);
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0100) $display("FAIL mrst_ready_w1: got %b want 0100", req_ready); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_total++; if (out_val !== 1'b0) $display("FAIL mrst_val_drop: got %0b want 0", out_val); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL mrst_ready_drop: got %b want 0000", req_ready); else n_pass++;
      n_total++; if ({busy, gnt_id} !== 3'b000) $display("FAIL mrst_state: got %b want 000", {busy, gnt_id}); else n_pass++;
      step();
      set_req(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      step();
      reset = 1'b0;
      set_req(0, 1'b1, 1'b1, 1'b1, 8'd4, 8'h40);
      set_req(1, 1'b1, 1'b1, 1'b1, 8'd4, 8'h41);
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd0) $display("FAIL mrst_rrptr_gnt: got %0d want 0", gnt_id); else n_pass++;
      step();
      set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
   endtask

   task automatic test_multi();
      step();
      set_req(1, 1'b1, 1'b1, 1'b0, 8'd160, 8'h11);
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd1) $display("FAIL multi_gnt_w0: got %0d want 1", gnt_id); else n_pass++;
      n_total++; if (out_vbc !== 8'd160) $display("FAIL multi_vbc_w0: got %0d want 160", out_vbc); else n_pass++;
      step();
      set_req(1, 1'b1, 1'b0, 1'b1, 8'd1, 8'h22);
      set_req(0, 1'b1, 1'b1, 1'b1, 8'd8, 8'h0A);
      out_ready = 1'b0;
      @(negedge clk);
      n_total++; if (err !== 1'b0) $display("FAIL multi_vbc160_err: got %0b want 0", err); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL multi_stall_ready: got %b want 0000", req_ready); else n_pass++;
      n_total++; if ({busy, out_val} !== 2'b11) $display("FAIL multi_stall_hold: got %b want 11", {busy, out_val}); else n_pass++;
      step();
      out_ready = 1'b1;
      @(negedge clk);
      exp_d = {IB{8'h22}};
      n_total++; if (gnt_id !== 2'd1) $display("FAIL multi_gnt_w1: got %0d want 1", gnt_id); else n_pass++;
      n_total++; if (out_data !== exp_d) $display("FAIL multi_data_w1: got %0h want %0h", out_data[15:0], exp_d[15:0]); else n_pass++;
      n_total++; if (req_ready !== 4'b0010) $display("FAIL multi_ready_w1: got %b want 0010", req_ready); else n_pass++;
      step();
      set_req(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      n_total++; if ({busy, err} !== 2'b00) $display("FAIL multi_done: got %b want 00", {busy, err}); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd0) $display("FAIL multi_next_gnt: got %0d want 0", gnt_id); else n_pass++;
      step();
      set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
   endtask

   task automatic test_sop_err();
      step();
      set_req(2, 1'b1, 1'b1, 1'b0, 8'd8, 8'h50);
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd2) $display("FAIL soperr_gnt: got %0d want 2", gnt_id); else n_pass++;
      step();
      // second word: sop mid-packet and vbc 0 together, code 0 must win
      set_req(2, 1'b1, 1'b1, 1'b0, 8'd0, 8'h51);
      @(negedge clk);
      n_total++; if (err !== 1'b0) $display("FAIL soperr_w0_err: got %0b want 0", err); else n_pass++;
      step();
      set_req(2, 1'b1, 1'b0, 1'b1, 8'd8, 8'h52);
      @(negedge clk);
      n_total++; if (err !== 1'b1) $display("FAIL soperr_err: got %0b want 1", err); else n_pass++;
      n_total++; if (err_code !== 2'd0) $display("FAIL soperr_code: got %0d want 0", err_code); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL soperr_continue: got %0b want 1", busy); else n_pass++;
      step();
      set_req(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      n_total++; if ({busy, err} !== 2'b00) $display("FAIL soperr_done: got %b want 00", {busy, err}); else n_pass++;
   endtask

   task automatic test_vbc_err();
      step();
      set_req(3, 1'b1, 1'b1, 1'b1, 8'd161, 8'h60);
      step();
      @(negedge clk);
      n_total++; if (gnt_id !== 2'd3) $display("FAIL vbcerr_gnt: got %0d want 3", gnt_id); else n_pass++;
      step();
      set_req(3, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      n_total++; if ({err, err_code} !== 3'b110) $display("FAIL vbcerr_code: got %b want 110", {err, err_code}); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (err !== 1'b0) $display("FAIL vbcerr_pulse: got %0b want 0", err); else n_pass++;
   endtask

   task automatic test_rotation();
      int pkt_cnt;
      int exp_g;
      pkt_cnt = 0;
      step();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 1'b1, 8'(10 + i), 8'(i));
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         exp_g = (c / 2) % NR;
         n_total++; if (out_val !== ((c % 2) == 0)) $display("FAIL rot_val_c%0d: got %0b want %0b", c, out_val, (c % 2) == 0); else n_pass++;
         if (out_val === 1'b1) begin
            pkt_cnt++;
            n_total++; if (gnt_id !== 2'(exp_g)) $display("FAIL rot_gnt_c%0d: got %0d want %0d", c, gnt_id, exp_g); else n_pass++;
            n_total++; if (out_vbc !== 8'(10 + exp_g)) $display("FAIL rot_vbc_c%0d: got %0d want %0d", c, out_vbc, 10 + exp_g); else n_pass++;
         end
      end
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      n_total++; if (pkt_cnt !== 8) $display("FAIL rot_pkt_cnt: got %0d want 8", pkt_cnt); else n_pass++;
   endtask

`ifdef UNPACKER_ARB_TIMEOUT_EN
   task automatic test_timeout();
      step();
      set_req(0, 1'b1, 1'b1, 1'b0, 8'd8, 8'h70);
      step();
      step();
      set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      set_req(1, 1'b1, 1'b1, 1'b1, 8'd8, 8'h71);
      repeat (63) @(posedge clk);
      @(negedge clk);
      n_total++; if ({busy, err} !== 2'b10) $display("FAIL tmo_pre: got %b want 10", {busy, err}); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_total++; if ({err, err_code, busy} !== 4'b1110) $display("FAIL tmo_fire: got %b want 1110", {err, err_code, busy}); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_total++; if ({busy, gnt_id} !== 3'b101) $display("FAIL tmo_next_gnt: got %b want 101", {busy, gnt_id}); else n_pass++;
      step();
      set_req(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
   endtask
`endif

   initial begin
      clk       = 1'b0;
      reset     = 1'b1;
      req_val   = '0;
      req_sop   = '0;
      req_eop   = '0;
      req_vbc   = '0;
      req_data  = '0;
      out_ready = 1'b0;
      n_pass    = 0;
      n_total   = 0;
      test_reset();
      test_single();
      test_mid_reset();
      test_multi();
      test_sop_err();
      test_vbc_err();
      test_rotation();
`ifdef UNPACKER_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
